regfile_wb_arbiter: RTL

//  Owns the single write port of the 32x32 register file. Shares it between the ALU

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 40 ++++
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback path.
// Provides the register file geometry, the writeback request bundle,
// the arbiter FSM state encoding and the writeback source identifiers.
package rf_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} wb_state_t;

  // Source index doubles as the bit position in the arbiter req/gnt vectors.
  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} wb_src_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   en        arbitration enabled; no grants and no state change when low
//   req[1:0]  requests, bit index is a wb_src_t value
//   gnt[1:0]  one-hot (or zero) grant, combinational from req/en/rr_last
// rr_last remembers the winner of the last contested cycle and only moves
// when both inputs request, so each side waits at most one cycle.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_t rr_last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) begin
        if (rr_last == SRC_ALU) gnt[SRC_MEM] = 1'b1;
        else                    gnt[SRC_ALU] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_last <= SRC_ALU;
    else if (en && (&req))
      rr_last <= (rr_last == SRC_ALU) ? SRC_MEM : SRC_ALU;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owner of the register file write port.
// After reset an optional sweep zeroes x1..x(NUM_REGS-1); afterwards ALU and
// load writebacks share the port through a round-robin arbiter. The granted
// request is registered onto rf_* one cycle later.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   alu_valid/rd/data, alu_ready   ALU writeback handshake
//   mem_valid/rd/data, mem_ready   load writeback handshake
//   rs1, rs2 -> rs1/rs2_pending    RAW hazard query for decode
//   rf_reg_write, rf_rd, rf_write_data   register file write port
//   busy                           clear sweep in progress
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REGS = rf_pkg::NUM_REGS,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_pending,
  output logic              rs2_pending,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  wb_state_t         state;
  logic [ADDR_W-1:0] clr_idx;
  wb_req_t           alu_req, mem_req, sel;
  logic [1:0]        gnt;
  logic              arb_en;

  assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
  assign mem_req = '{valid: mem_valid, rd: mem_rd, data: mem_data};

  // Readies stay low while reset is held so nothing is accepted that the
  // reset edge would then discard.
  assign arb_en = (state == RUN) && !rst;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req ({mem_req.valid, alu_req.valid}),
    .gnt (gnt)
  );

  assign alu_ready = gnt[SRC_ALU];
  assign mem_ready = gnt[SRC_MEM];
  assign sel       = gnt[SRC_MEM] ? mem_req : alu_req;
  assign busy      = (state == CLEAR);

  // Outstanding = already on the write port, or still waiting at either source.
  function automatic logic pend(input logic [ADDR_W-1:0] rs);
    return (rs != '0) &&
           ((rf_reg_write && (rf_rd  == rs)) ||
            (alu_valid    && (alu_rd == rs)) ||
            (mem_valid    && (mem_rd == rs)));
  endfunction

  // During the sweep every register is being rewritten, so stall all reads.
  assign rs1_pending = busy || pend(rs1);
  assign rs2_pending = busy || pend(rs2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= CLEAR_EN ? CLEAR : RUN;
      clr_idx       <= ADDR_W'(1);
      rf_reg_write  <= 1'b0;
      rf_rd         <= '0;
      rf_write_data <= '0;
    end else if (state == CLEAR) begin
      rf_reg_write  <= 1'b1;
      rf_rd         <= clr_idx;
      rf_write_data <= '0;
      clr_idx       <= clr_idx + ADDR_W'(1);
      if (clr_idx == LAST_IDX) state <= RUN;
    end else if (|gnt) begin
      // x0 writes are accepted but never reach the file.
      rf_reg_write  <= (sel.rd != '0);
      rf_rd         <= sel.rd;
      rf_write_data <= sel.data;
    end else begin
      rf_reg_write  <= 1'b0;
    end
  end

endmodule
